// File: rtl/dds_chirp_pkg.sv
// dds_chirp_pkg: FSM state type and widened-compare width helper for the chirp sequencer.
package dds_chirp_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cmp_width(input int w);
        return w + 1;
    endfunction
endpackage

// File: rtl/dds_chirp_step.sv
// dds_chirp_step: next-FTW adder and signed overshoot compare, one bit wider than the FTW so nothing wraps.
module dds_chirp_step
    import dds_chirp_pkg::*;
#(
    parameter int G_FTW_WIDTH = 24
) (
    input  logic [G_FTW_WIDTH-1:0] ftw,
    input  logic signed [G_FTW_WIDTH:0] step,
    input  logic [G_FTW_WIDTH-1:0] bound,
    output logic [G_FTW_WIDTH-1:0] next,
    output logic end_sweep
);
    localparam int CW = cmp_width(G_FTW_WIDTH);
    logic signed [CW-1:0] sum, bnd;
    assign sum = $signed({ftw[G_FTW_WIDTH-1], ftw}) + step;
    assign bnd = $signed({bound[G_FTW_WIDTH-1], bound});
    assign next = sum[G_FTW_WIDTH-1:0];
    assign end_sweep = (step == '0) || (!step[CW-1] && sum > bnd) || (step[CW-1] && sum < bnd);
endmodule

// File: rtl/dds_chirp_ctrl.sv
// dds_chirp_ctrl: chirp FTW sequencer feeding a DDS valid/ready input.
// Define DDS_CHIRP_TRIANGLE_EN for up/down triangle sweeps instead of sawtooth.
module dds_chirp_ctrl
    import dds_chirp_pkg::*;
#(
    parameter int G_FTW_WIDTH = 24,
    parameter int G_DWELL_WIDTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic start,
    input  logic cont,
    input  logic [G_FTW_WIDTH-1:0] ftw_start,
    input  logic [G_FTW_WIDTH-1:0] ftw_stop,
    input  logic [G_FTW_WIDTH-1:0] ftw_step,
    input  logic [G_DWELL_WIDTH-1:0] dwell,
    output logic [G_FTW_WIDTH-1:0] dout,
    output logic dout_valid,
    input  logic dout_ready,
    output logic busy,
    output logic done
);
    localparam int W = G_FTW_WIDTH;
    state_t state_q, state_d;
    logic [W-1:0] ftw_q, ftw_d, start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [G_DWELL_WIDTH-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic cont_q, cont_d, dir_q, reverse, beat, last, end_sweep;
    logic signed [W:0] step_w, rev_w;
    logic [W-1:0] bound, next;
`ifdef DDS_CHIRP_TRIANGLE_EN
    logic dir_d;
    assign step_w = dir_q ? -$signed({step_q[W-1], step_q}) : $signed({step_q[W-1], step_q});
    assign bound = dir_q ? start_q : stop_q;
    // Reverse at the top vertex unless the first downward value already lies past ftw_start.
    assign reverse = !dir_q && step_q != '0 &&
        !(step_w[W] ? rev_w > $signed({start_q[W-1], start_q}) : rev_w < $signed({start_q[W-1], start_q}));
    always_comb begin
        dir_d = dir_q;
        if (state_q != RUN) dir_d = 1'b0;
        else if (beat && last && end_sweep) dir_d = reverse;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) dir_q <= 1'b0;
        else dir_q <= dir_d;
`else
    assign dir_q = 1'b0;
    assign reverse = 1'b0;
    assign step_w = $signed({step_q[W-1], step_q});
    assign bound = stop_q;
`endif
    assign rev_w = $signed({ftw_q[W-1], ftw_q}) - step_w;
    dds_chirp_step #(.G_FTW_WIDTH(W)) u_step (
        .ftw(ftw_q), .step(step_w), .bound(bound), .next(next), .end_sweep(end_sweep)
    );
    assign dout = ftw_q;
    assign dout_valid = state_q == RUN;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign beat = dout_valid && dout_ready;
    assign last = cnt_q == ((dwell_q == '0) ? '0 : dwell_q - 1'b1);
    always_comb begin
        state_d = state_q;
        ftw_d = ftw_q;
        start_d = start_q;
        stop_d = stop_q;
        step_d = step_q;
        dwell_d = dwell_q;
        cont_d = cont_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                ftw_d = ftw_start;
                start_d = ftw_start;
                stop_d = ftw_stop;
                step_d = ftw_step;
                dwell_d = dwell;
                cont_d = cont;
                cnt_d = '0;
            end
            RUN: if (beat) begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    if (!end_sweep) ftw_d = next;
                    else if (reverse) ftw_d = rev_w[W-1:0];
                    else if (cont_q) ftw_d = dir_q ? rev_w[W-1:0] : start_q;
                    else state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ftw_q <= '0;
            start_q <= '0;
            stop_q <= '0;
            step_q <= '0;
            dwell_q <= '0;
            cont_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ftw_q <= ftw_d;
            start_q <= start_d;
            stop_q <= stop_d;
            step_q <= step_d;
            dwell_q <= dwell_d;
            cont_q <= cont_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dds_chirp_ctrl.sv
// tb_dds_chirp_ctrl: directed-vector bench for dds_chirp_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_dds_chirp_ctrl;
    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, start = 1'b0, cont = 1'b0, dout_ready = 1'b1;
    logic [23:0] ftw_start = '0, ftw_stop = '0, ftw_step = '0, dout;
    logic [15:0] dwell = '0;
    logic dout_valid, busy, done;
    int vectors = 0, errors = 0;
    int exp_q[$];
    always #5 clk = ~clk;
    dds_chirp_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .cont(cont),
        .ftw_start(ftw_start), .ftw_stop(ftw_stop), .ftw_step(ftw_step), .dwell(dwell),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
    );
    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cfg(input int s, input int e, input int st, input int d, input bit c);
        ftw_start = s[23:0];
        ftw_stop = e[23:0];
        ftw_step = st[23:0];
        dwell = d[15:0];
        cont = c;
    endtask
    task automatic run(input bit bp, input int max_beats);
        int k = 0;
        logic [23:0] held = '0;
        bit hold = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_valid", int'(dout_valid), 1);
        for (int cyc = 0; cyc < 300 && dout_valid; cyc++) begin
            if (hold) check("stable", int'($signed(dout)), int'($signed(held)));
            if (dout_ready) begin
                if (k < exp_q.size()) check("beat", int'($signed(dout)), exp_q[k]);
                k++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                held = dout;
            end
            if (k == max_beats) break;
            @(negedge clk);
            if (bp) dout_ready = ~dout_ready;
        end
        dout_ready = 1'b1;
        check("beat_count", k, exp_q.size());
    endtask
    task automatic end_oneshot();
        check("valid_low", int'(dout_valid), 0);
        check("done_pulse", int'(done), 1);
        check("busy_low", int'(busy), 0);
        @(negedge clk);
        check("done_clear", int'(done), 0);
    endtask
    task automatic abort_cont();
        enable = 1'b0;
        @(negedge clk);
        check("abort_valid", int'(dout_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        enable = 1'b1;
        @(negedge clk);
        check("stay_idle", int'(dout_valid), 0);
        check("no_done", int'(done), 0);
    endtask
    initial begin
        @(negedge clk);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clk);
        cfg(100, 130, 10, 2, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_disabled", int'(dout_valid), 0);
        enable = 1'b1;
        @(negedge clk);
        check("still_idle", int'(busy), 0);
`ifdef DDS_CHIRP_TRIANGLE_EN
        cfg(0, 20, 10, 1, 0);
        exp_q = '{0, 10, 20, 10, 0};
        run(1'b0, -1);
        end_oneshot();
        cfg(0, 20, 10, 1, 1);
        exp_q = '{0, 10, 20, 10, 0, 10, 20, 10, 0};
        run(1'b0, 9);
        abort_cont();
`else
        exp_q = '{100, 100, 110, 110, 120, 120, 130, 130};
        run(1'b0, -1);
        end_oneshot();
        run(1'b1, -1);
        end_oneshot();
        cfg(5, -20, -10, 1, 0);
        exp_q = '{5, -5, -15};
        run(1'b0, -1);
        end_oneshot();
        cfg(0, 2, 1, 0, 1);
        exp_q = '{0, 1, 2, 0, 1, 2, 0};
        run(1'b0, 7);
        abort_cont();
`endif
        cfg(50, 10, 5, 3, 0);
        exp_q = '{50, 50, 50};
        run(1'b0, -1);
        end_oneshot();
        cfg(7, 100, 0, 2, 0);
        exp_q = '{7, 7};
        run(1'b0, -1);
        end_oneshot();
        cfg(100, 130, 10, 2, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", int'(dout_valid), 0);
        check("async_dout", int'(dout), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", int'(dout_valid), 0);
        check("post_rst_busy", int'(busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
